// File: rtl/area_pkg.sv
// Shared types and constants for the pool-area sequencer.
package area_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SQ   = 3'd1,
      CIRC = 3'd2,
      SUM  = 3'd3,
      HOLD = 3'd4
   } state_t;

   localparam logic [1:0] MODE_TOTAL = 2'b00;
   localparam logic [1:0] MODE_SQ    = 2'b01;
   localparam logic [1:0] MODE_CIRC  = 2'b10;

   // pi/4 scaled by 256, applied as (w*w*201) >> 8
   localparam int unsigned CIRC_COEF  = 201;
   localparam int unsigned CIRC_SHIFT = 8;

endpackage

// File: rtl/area_mul16.sv
// Combinational 16x16 unsigned multiplier; the single shared arithmetic
// resource scheduled by the sequencer.
module area_mul16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [31:0] p
);

   // full-width unsigned product
   assign p = 32'(a) * 32'(b);

endmodule

// File: rtl/area_seq_ctrl.sv
// Pool-area sequencer: square of the width plus a circle of the same
// diameter, computed over several cycles on one shared multiplier.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request; in_ready high
// SQ    | multiplier forms width*width, result into sq_r
// CIRC  | multiplier forms sq_r*coef, scaled result into circ_r
// SUM   | area selected by mode and registered; out_valid raised
// HOLD  | area presented until the consumer takes it
module area_seq_ctrl #(
   parameter int unsigned CIRC_COEF  = area_pkg::CIRC_COEF,
   parameter int unsigned CIRC_SHIFT = area_pkg::CIRC_SHIFT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  width,
   input  logic [1:0]  mode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [16:0] area,
   output logic        busy
);

   import area_pkg::*;

   localparam logic [15:0] COEF16 = 16'(CIRC_COEF);

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  width_r;
   logic [1:0]  mode_r;
   logic [15:0] sq_r;
   logic [15:0] circ_r;
   logic [15:0] mul_a;
   logic [15:0] mul_b;
   logic [31:0] mul_p;
   logic [16:0] sum_sel;
   logic        unused_mul_hi;

   area_mul16 u_mul (
      .a (mul_a),
      .b (mul_b),
      .p (mul_p)
   );

   // Upper product bits are provably zero in CIRC (201*65025 < 2^24).
   assign unused_mul_hi = ^mul_p[31:CIRC_SHIFT+16];

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and multiplier operand schedule; operands parked at 0 when idle
   always_comb begin
      state_nxt = state;
      mul_a     = '0;
      mul_b     = '0;
      case (state)
         IDLE: begin
            if (in_valid) state_nxt = SQ;
         end
         SQ: begin
            mul_a     = {8'h00, width_r};
            mul_b     = {8'h00, width_r};
            state_nxt = CIRC;
         end
         CIRC: begin
            mul_a     = sq_r;
            mul_b     = COEF16;
            state_nxt = SUM;
         end
         SUM: begin
            state_nxt = HOLD;
         end
         HOLD: begin
            if (out_valid && out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Result selection by captured mode; reserved code falls back to total
   always_comb begin
      sum_sel = {1'b0, sq_r} + {1'b0, circ_r};
      case (mode_r)
         MODE_SQ:   sum_sel = {1'b0, sq_r};
         MODE_CIRC: sum_sel = {1'b0, circ_r};
         default:   sum_sel = {1'b0, sq_r} + {1'b0, circ_r};
      endcase
   end

   // Request capture, partial-product registers and output handshake
   always_ff @(posedge clk) begin
      if (!rst) begin
         width_r   <= '0;
         mode_r    <= MODE_TOTAL;
         sq_r      <= '0;
         circ_r    <= '0;
         area      <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  width_r <= width;
                  mode_r  <= mode;
               end
            end
            SQ:   sq_r   <= mul_p[15:0];
            CIRC: circ_r <= mul_p[CIRC_SHIFT +: 16];
            SUM: begin
               area      <= sum_sel;
               out_valid <= 1'b1;
            end
            HOLD: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_area_seq_ctrl.sv
// Bench for the pool-area sequencer: directed latency/backpressure/reset
// cases, then a randomized stream scored against a reference queue.
module tb_area_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  width;
   logic [1:0]  mode;
   logic        out_valid;
   logic        out_ready;
   logic [16:0] area;
   logic        busy;

   int n_chk  = 0;
   int n_pass = 0;

   area_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .width     (width),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .area      (area),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Reference: area from the arithmetic definition, no notion of cycles.
   function automatic int unsigned ref_area(input int unsigned w, input int unsigned m);
      int unsigned sq, circ;
      sq   = w * w;
      circ = (sq * 201) / 256;
      case (m)
         1:       return sq;
         2:       return circ;
         default: return sq + circ;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One request with fixed latency checks; 'stall' cycles of out_ready low
   // in HOLD, optionally with a competing request held on the input.
   task automatic do_txn(input int w, input int m, input int stall, input bit compete);
      logic [16:0] held;
      chk("rdy_before", 32'(in_ready), 1);
      in_valid  = 1'b1;
      width     = 8'(w);
      mode      = 2'(m);
      out_ready = (stall == 0);
      tick();                                   // edge 0: accept
      in_valid = 1'b0;
      width    = 8'hxx;
      chk("rdy_low_sq", 32'(in_ready), 0);
      chk("busy_sq", 32'(busy), 1);
      tick();                                   // edge 1
      tick();                                   // edge 2
      chk("ov_early", 32'(out_valid), 0);
      tick();                                   // edge 3
      chk("ov_rise", 32'(out_valid), 1);
      chk("area", 32'(area), ref_area(w, m));
      held = area;
      if (compete) begin
         in_valid = 1'b1;
         width    = 8'd5;
         mode     = 2'd0;
      end
      for (int i = 0; i < stall; i++) begin
         tick();
         chk("ov_hold", 32'(out_valid), 1);
         chk("area_hold", 32'(area), 32'(held));
         chk("rdy_hold", 32'(in_ready), 0);
      end
      out_ready = 1'b1;
      tick();                                   // output handshake
      out_ready = 1'b0;
      chk("ov_clear", 32'(out_valid), 0);
      chk("rdy_idle", 32'(in_ready), 1);
      chk("area_keep", 32'(area), 32'(held));
   endtask

   typedef struct { int w; int m; } req_t;
   int unsigned exp_q[$];
   int          n_got;
   bit          prod_done;

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      width     = '0;
      mode      = '0;
      out_ready = 1'b0;
      tick();
      tick();
      chk("rst_area", 32'(area), 0);
      chk("rst_ov", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rdy", 32'(in_ready), 1);
      rst = 1'b1;
      tick();
      chk("post_rst_rdy", 32'(in_ready), 1);

      do_txn(10, 0, 0, 0);
      do_txn(255, 0, 0, 0);
      do_txn(0, 0, 0, 0);
      do_txn(16, 0, 0, 0);
      do_txn(10, 1, 0, 0);
      do_txn(10, 2, 0, 0);
      do_txn(10, 3, 0, 0);

      // backpressure with a competing request that must not be taken early
      do_txn(200, 0, 10, 1);
      chk("compete_width", 32'(width), 5);
      do_txn(5, 0, 0, 0);

      // reset while in CIRC
      in_valid = 1'b1;
      width    = 8'd77;
      mode     = 2'd0;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_ov", 32'(out_valid), 0);
      chk("abort_area", 32'(area), 0);
      out_ready = 1'b1;
      begin
         int spurious = 0;
         for (int i = 0; i < 6; i++) begin
            if (out_valid) spurious++;
            tick();
         end
         chk("abort_no_result", 32'(spurious), 0);
      end
      out_ready = 1'b0;
      do_txn(12, 0, 0, 0);

      // randomized back-to-back stream with random consumer stalls
      n_got     = 0;
      prod_done = 1'b0;
      fork
         begin : producer
            for (int k = 0; k < 20; k++) begin
               int w, m, budget;
               bit sent;
               w = int'($urandom_range(0, 255));
               m = int'($urandom_range(0, 3));
               in_valid = 1'b1;
               width    = 8'(w);
               mode     = 2'(m);
               sent     = 1'b0;
               budget   = 0;
               while (!sent && budget < 200) begin
                  if (in_ready) begin
                     exp_q.push_back(ref_area(w, m));
                     sent = 1'b1;
                  end
                  tick();
                  budget++;
               end
               in_valid = 1'b0;
               if (!sent) chk("prod_timeout", 0, 1);
               if ($urandom_range(0, 3) == 0) tick();
            end
            prod_done = 1'b1;
         end
         begin : consumer
            int budget;
            budget = 0;
            while (n_got < 20 && budget < 3000) begin
               out_ready = ($urandom_range(0, 2) != 0);
               if (out_valid && out_ready) begin
                  if (exp_q.size() == 0) begin
                     chk("stream_extra", 32'(area), 32'hFFFF_FFFF);
                  end else begin
                     chk("stream_area", 32'(area), exp_q.pop_front());
                  end
                  n_got++;
               end
               tick();
               budget++;
            end
            out_ready = 1'b0;
         end
      join
      chk("stream_count", 32'(n_got), 20);
      chk("stream_leftover", 32'(exp_q.size()), 0);
      chk("stream_prod_done", 32'(prod_done), 1);
      out_ready = 1'b1;
      begin
         int extra = 0;
         for (int i = 0; i < 8; i++) begin
            if (out_valid) extra++;
            tick();
         end
         chk("stream_no_dup", 32'(extra), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
